// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter for SLL/SRA/SRL: moves one bit position per clock under a
// start/done handshake and holds its result in a register for the writeback mux.
module iter_shift_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       alu,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    // Handshake: start is accepted on a rising edge only in IDLE or DONE and
    // only without flush; busy is high exactly in SHIFT; done is a one-cycle
    // pulse while out holds the fresh result.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRA  = 2'b01;
    localparam logic [1:0] OP_SRL  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] shifted;
    logic [1:0]       op;
    logic [SHW-1:0]   count;
    logic             accept;
    logic             immediate;
    logic             last_step;

    assign accept    = (state != SHIFT) && start && !flush;
    assign immediate = (shamt == '0) || (alu == OP_PASS);
    assign last_step = (count == SHW'(1));

    always_comb begin
        shifted = work;
        case (op)
            OP_SLL:  shifted = {work[WIDTH-2:0], 1'b0};
            OP_SRA:  shifted = {work[WIDTH-1], work[WIDTH-1:1]};
            OP_SRL:  shifted = {1'b0, work[WIDTH-1:1]};
            default: shifted = work;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = immediate ? DONE : SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Flush overrides everything, including a start in the same cycle.
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work  <= '0;
            op    <= OP_SLL;
            count <= '0;
            out   <= '0;
        end else if (accept) begin
            work  <= in;
            op    <= alu;
            count <= shamt;
            if (immediate) begin
                out <= in;
            end
        end else if (state == SHIFT && !flush) begin
            work  <= shifted;
            count <= count - SHW'(1);
            if (last_step) begin
                out <= shifted;
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_iter_shift_unit.sv
// Bench for iter_shift_unit: directed scenarios plus random operations checked
// against an arithmetic shift model with expected latency and result.
module tb_iter_shift_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [31:0] in;
    logic [4:0]  shamt;
    logic [1:0]  alu;
    logic        busy;
    logic        done;
    logic [31:0] out;

    int          vectors;
    int          miscompares;
    logic [31:0] last_out;

    iter_shift_unit #(.WIDTH(32), .SHW(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .flush (flush),
        .in    (in),
        .shamt (shamt),
        .alu   (alu),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s observed=0x%08h required=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input int s, input logic [1:0] op);
        case (op)
            2'b00:   return a << s;
            2'b01:   return 32'($signed(a) >>> s);
            2'b10:   return a >> s;
            default: return a;
        endcase
    endfunction

    function automatic int ref_latency(input int s, input logic [1:0] op);
        return (s == 0 || op == 2'b11) ? 0 : s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call just after an edge; waits until done, checking busy and held out.
    task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp);
        int lat;
        lat = 0;
        while (!done && lat < 40) begin
            check({tag, "_busy"}, {31'b0, busy}, 32'd1);
            check({tag, "_hold"}, out, last_out);
            step();
            lat++;
        end
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_excl"}, {31'b0, busy}, 32'd0);
        check({tag, "_out"}, out, exp);
        last_out = exp;
    endtask

    // Presents a start for one edge, scrambles inputs, then waits for completion.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] s, input logic [1:0] op);
        start = 1'b1;
        in    = a;
        shamt = s;
        alu   = op;
        step();
        start = 1'b0;
        in    = $urandom;
        shamt = 5'($urandom_range(0, 31));
        alu   = 2'($urandom_range(0, 3));
        wait_done(tag, ref_latency(int'(s), op), ref_shift(a, int'(s), op));
    endtask

    task automatic idle_check(input string tag);
        step();
        check({tag, "_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_held"}, out, last_out);
    endtask

    initial begin
        int saw_done;
        logic [31:0] ra;
        logic [4:0]  rs;
        logic [1:0]  ro;
        vectors     = 0;
        miscompares = 0;
        last_out    = '0;
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        in    = '0;
        shamt = '0;
        alu   = '0;
        repeat (3) step();
        check("reset_out", out, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        rst = 1'b0;
        step();

        // Zero shift and pass-through complete right after the accept edge.
        run_op("zero_shamt", 32'hDEAD_BEEF, 5'd0, 2'b00);
        idle_check("zero_shamt");
        run_op("pass", 32'h1234_5678, 5'd7, 2'b11);
        idle_check("pass");

        // Reset in the middle of a shift: everything clears, no done follows.
        start = 1'b1; in = 32'h1; shamt = 5'd20; alu = 2'b00;
        step();
        start = 1'b0;
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        check("rst_mid_out", out, 32'h0);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_done", {31'b0, done}, 32'd0);
        step();
        rst = 1'b0;
        last_out = '0;
        saw_done = 0;
        repeat (25) begin
            step();
            if (done || busy) saw_done = 1;
        end
        check("rst_mid_no_done", saw_done, 0);

        // Full-width SLL and the two right shifts on a negative operand.
        run_op("sll31", 32'h0000_0001, 5'd31, 2'b00);
        idle_check("sll31");
        run_op("sra4", 32'h8000_00F0, 5'd4, 2'b01);
        idle_check("sra4");
        run_op("srl4", 32'h8000_00F0, 5'd4, 2'b10);
        idle_check("srl4");

        // A start during SHIFT is ignored; a start held in DONE is accepted.
        start = 1'b1; in = 32'hFFFF_FFFF; shamt = 5'd3; alu = 2'b10;
        step();
        in = 32'h0; shamt = 5'd1; alu = 2'b00;
        step();
        start = 1'b0;
        wait_done("busy_ignore", 2, 32'h1FFF_FFFF);
        run_op("b2b", 32'h1, 5'd2, 2'b00);
        idle_check("b2b");

        // Flush with a simultaneous start: start is dropped and out is kept.
        start = 1'b1; in = 32'h1; shamt = 5'd10; alu = 2'b00;
        step();
        start = 1'b0;
        repeat (3) step();
        flush = 1'b1; start = 1'b1; in = 32'hCAFE_F00D; shamt = 5'd0; alu = 2'b11;
        step();
        flush = 1'b0; start = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_done", {31'b0, done}, 32'd0);
        check("flush_out", out, last_out);
        saw_done = 0;
        repeat (15) begin
            step();
            if (done || busy || out !== last_out) saw_done = 1;
        end
        check("flush_quiet", saw_done, 0);

        // Flush while in DONE: the pulse still shows, then back to idle.
        run_op("pre_flush_done", 32'h0000_00FF, 5'd1, 2'b00);
        flush = 1'b1; start = 1'b1; in = 32'h5555_5555; shamt = 5'd0; alu = 2'b11;
        step();
        flush = 1'b0; start = 1'b0;
        check("flush_done_state", {30'b0, busy, done}, 32'd0);
        check("flush_done_out", out, 32'h0000_01FE);

        // Random operations, half of them issued back-to-back from DONE.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rs = 5'($urandom_range(0, 31));
            ro = 2'($urandom_range(0, 3));
            run_op("rand", ra, rs, ro);
            if ($urandom_range(0, 1) == 0) idle_check("rand");
        end
        idle_check("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iter_shift_unit.md
Name: iter_shift_unit

Overview:
- Multi-cycle shift unit for the area-reduced RV32 core variant; replaces the single-cycle barrel shifter for SLL/SRL/SRA (and their immediate forms).
- Executes one bit position per clock under a start/done handshake and holds its result for the ALU writeback mux.
- Operation encoding and shift semantics match the existing combinational shifter.
- The pipeline control stalls on busy.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on rising clk; accepted only in IDLE or DONE.
- flush  input  1  synchronous abort of the operation in progress.
- in  input  WIDTH  operand, captured on accepted start.
- shamt  input  SHW  shift amount, captured on accepted start.
- alu  input  2  operation, captured on accepted start: 00 SLL, 01 SRA, 10 SRL, 11 pass-through.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; result valid on out.
- out  output  WIDTH  result register; holds its value until the next completion.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, out=0, working reg=0, count=0. Reset mid-operation discards the operation with no done pulse.
- States:
  - IDLE: waits for start.
  - SHIFT: iterating.
  - DONE: single cycle with done=1, then returns to IDLE unless a new start is accepted.
- Accept (edge T, state IDLE or DONE, start=1, flush=0):
  - Latch in into the working reg, alu into the op reg, shamt into count.
  - If shamt==0 or alu==11: out<=in, next state DONE.
  - Otherwise: next state SHIFT.
- SHIFT, each edge:
  - Working reg shifts one position.
    - SLL: left, fill with 0.
    - SRL: right, fill with 0.
    - SRA: right, fill with current bit WIDTH-1.
  - count decrements.
  - When count==1 at the edge: out<=shifted value, next state DONE.
- Latency: done is high in the cycle following edge T+shamt. shamt=0 gives done right after the accept edge; shamt=31 gives done 31 edges after accept.
- Throughput: a start in the DONE cycle is accepted, giving back-to-back operations with no idle bubble.
- start while busy=1 is ignored. The captured operands are unaffected, and no queueing occurs.
- flush=1 at any edge:
  - Next state IDLE, busy=0, done=0.
  - out is unchanged.
  - flush and start in the same cycle: flush wins and start is dropped.
  - flush in DONE: done still shows for that cycle (already registered); next state IDLE.
- out changes only on entry to DONE. out is stable during SHIFT and IDLE.
- Input changes after acceptance have no effect.
- busy and done are never high simultaneously. busy=1 exactly in SHIFT.
- Arithmetic: count width is SHW. No wrap handling is needed because shamt≤WIDTH-1.

Test Plan:
1. Reset mid-op: start SLL in=0x0000_0001 shamt=20, assert rst after 5 cycles -> out=0, busy=0, done=0 immediately; no done pulse follows.
2. SLL: in=0x0000_0001, shamt=31, alu=00 -> busy for 31 cycles, done pulse on the cycle after edge T+31, out=0x8000_0000 and held afterwards.
3. SRA vs SRL: in=0x8000_00F0, shamt=4; alu=01 -> out=0xF800_000F; then alu=10 -> out=0x0800_000F. Latency is 4 in both cases.
4. Zero / pass-through: shamt=0 alu=00 in=0xDEAD_BEEF -> done the cycle after accept, out=0xDEAD_BEEF. Then alu=11 shamt=7 -> same one-cycle completion, out=in.
5. Back-to-back and ignore-while-busy:
   - start SRL in=0xFFFF_FFFF shamt=3; pulse start with new operands during SHIFT -> ignored, out=0x1FFF_FFFF.
   - start held in the DONE cycle with SLL in=0x1 shamt=2 -> accepted, out=0x4 two edges later.
6. Flush: start SLL shamt=10, flush after 4 cycles with start=1 the same cycle -> IDLE, no done, out keeps its previous value, start dropped.
